// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with NUM_RD combinational read ports, one write port and a
// per-register pending-write scoreboard. Optional macro REGFILE_BYPASS_EN adds write-through forwarding.

module regfile_sb_rd_port #(
  parameter int AW     = 5,
  parameter int DW     = 32,
  parameter int PEND_W = 2
) (
  input  logic [AW-1:0]                  ad,
  input  logic [2**AW-1:0][DW-1:0]       regs,
  input  logic [2**AW-1:0][PEND_W-1:0]   pend,
  input  logic                           we,
  input  logic [AW-1:0]                  wad,
  input  logic [DW-1:0]                  wd,
  output logic [DW-1:0]                  rd,
  output logic                           busy
);
  logic nz;
  assign nz = (ad != '0);

`ifdef REGFILE_BYPASS_EN
  logic hit;
  assign hit = we && (wad == ad) && nz;

  // A retiring writeback hiding the last pending write makes the operand ready this cycle.
  always_comb begin
    rd   = '0;
    busy = 1'b0;
    if (hit)     rd = wd;
    else if (nz) rd = regs[ad];
    if (nz) busy = (pend[ad] != '0) && !(hit && (pend[ad] == PEND_W'(1)));
  end
`else
  logic unused_wb;
  assign unused_wb = ^{we, wad, wd};

  always_comb begin
    rd   = '0;
    busy = 1'b0;
    if (nz) begin
      rd   = regs[ad];
      busy = (pend[ad] != '0);
    end
  end
`endif
endmodule

module regfile_sb #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_RD        = 2,
  parameter int PEND_W        = 2,
  parameter int DEBUG_REG     = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_RD*ADDRESS_WIDTH-1:0] AD_i,
  output logic [NUM_RD*DATA_WIDTH-1:0]    RD_o,
  output logic [NUM_RD-1:0]               busy_o,
  input  logic                            iss_valid_i,
  input  logic [ADDRESS_WIDTH-1:0]        iss_rd_i,
  output logic                            iss_ready_o,
  input  logic                            WE3_i,
  input  logic [ADDRESS_WIDTH-1:0]        AD3_i,
  input  logic [DATA_WIDTH-1:0]           WD3_i,
  input  logic                            flush_i,
  output logic [DATA_WIDTH-1:0]           a0_o
);
  localparam int                        NREG = 2**ADDRESS_WIDTH;
  localparam logic [PEND_W-1:0]         PMAX = '1;
  localparam logic [ADDRESS_WIDTH-1:0]  DBG  = ADDRESS_WIDTH'(DEBUG_REG);

  logic [NREG-1:0][DATA_WIDTH-1:0] regs;
  logic [NREG-1:0][PEND_W-1:0]     pend;
  logic [NREG-1:0]                 inc, dec;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          regs         <= '0;
    else if (WE3_i && AD3_i != '0)    regs[AD3_i]  <= WD3_i;
  end

  // A saturated destination is still accepted if this cycle's writeback retires one of its writes.
  assign iss_ready_o = !((iss_rd_i != '0) && (pend[iss_rd_i] == PMAX) &&
                         !(WE3_i && (AD3_i == iss_rd_i)));

  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 1; r < NREG; r++) begin
      inc[r] = iss_valid_i && iss_ready_o && (iss_rd_i == ADDRESS_WIDTH'(r));
      dec[r] = WE3_i && (AD3_i == ADDRESS_WIDTH'(r)) && (pend[r] != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          pend <= '0;
    else if (flush_i) pend <= '0;
    else begin
      for (int r = 1; r < NREG; r++) begin
        case ({inc[r], dec[r]})
          2'b10:   pend[r] <= pend[r] + PEND_W'(1);
          2'b01:   pend[r] <= pend[r] - PEND_W'(1);
          default: pend[r] <= pend[r];
        endcase
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_sb_rd_port #(
      .AW     (ADDRESS_WIDTH),
      .DW     (DATA_WIDTH),
      .PEND_W (PEND_W)
    ) u_rd (
      .ad   (AD_i[k*ADDRESS_WIDTH +: ADDRESS_WIDTH]),
      .regs (regs),
      .pend (pend),
      .we   (WE3_i),
      .wad  (AD3_i),
      .wd   (WD3_i),
      .rd   (RD_o[k*DATA_WIDTH +: DATA_WIDTH]),
      .busy (busy_o[k])
    );
  end

  assign a0_o = regs[DBG];
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed scenarios plus randomized traffic against an array-based reference model.
// Model follows REGFILE_BYPASS_EN the same way the design does.

module tb_regfile_sb;
  localparam int NR = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NR-1:0][4:0]  ad;
  logic [NR*32-1:0]    rd_o;
  logic [NR-1:0]       busy;
  logic                iv;
  logic [4:0]          ird;
  logic                ready;
  logic                we;
  logic [4:0]          wad;
  logic [31:0]         wd;
  logic                fl;
  logic [31:0]         a0;

  regfile_sb #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(NR), .PEND_W(2), .DEBUG_REG(10)) dut (
    .clk(clk), .rst(rst), .AD_i(ad), .RD_o(rd_o), .busy_o(busy),
    .iss_valid_i(iv), .iss_rd_i(ird), .iss_ready_o(ready),
    .WE3_i(we), .AD3_i(wad), .WD3_i(wd), .flush_i(fl), .a0_o(a0)
  );

  always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_regs [32];
  int          m_pend [32];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 0;
    end
  endtask

  function automatic logic [31:0] exp_rd(input int k);
    int a = int'(ad[k]);
    if (a == 0) return 32'h0;
    if (BYP && we && int'(wad) == a) return wd;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input int k);
    int a = int'(ad[k]);
    if (a == 0) return 1'b0;
    if (BYP && m_pend[a] == 1 && we && int'(wad) == a) return 1'b0;
    return m_pend[a] != 0;
  endfunction

  function automatic logic exp_ready();
    return !(ird != 0 && m_pend[ird] == 3 && !(we && wad == ird));
  endfunction

  task automatic check_all();
    for (int k = 0; k < NR; k++) begin
      chk($sformatf("rd%0d", k), rd_o[k*32 +: 32], exp_rd(k));
      chk($sformatf("busy%0d", k), {31'b0, busy[k]}, {31'b0, exp_busy(k)});
    end
    chk("iss_ready", {31'b0, ready}, {31'b0, exp_ready()});
    chk("a0", a0, m_regs[10]);
  endtask

  // Applies one rising edge to the model using the inputs currently driven.
  task automatic model_edge();
    logic acc = exp_ready();
    logic inc = iv && acc && ird != 0;
    logic dec = we && wad != 0 && m_pend[wad] > 0;
    if (we && wad != 0) m_regs[wad] = wd;
    if (fl) begin
      for (int i = 0; i < 32; i++) m_pend[i] = 0;
    end else if (!(inc && dec && ird == wad)) begin
      if (inc) m_pend[ird]++;
      if (dec) m_pend[wad]--;
    end
  endtask

  task automatic idle();
    iv = 0; ird = 0; we = 0; wad = 0; wd = 0; fl = 0;
  endtask

  task automatic cycle();
    #1 check_all();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    ad = '0;
    idle();
    model_reset();
    @(negedge clk); @(negedge clk);
    rst = 0;
    cycle();                                     // reset state

    // write x5, then asynchronous reset between edges
    we = 1; wad = 5; wd = 32'h1234; cycle();
    idle(); ad[0] = 5; #1 chk("x5_written", rd_o[31:0], 32'h1234);
    #2 rst = 1;
    #1 model_reset();
    chk("rst_rd", rd_o[31:0], 32'h0);
    chk("rst_a0", a0, 32'h0);
    chk("rst_busy", {29'b0, busy}, 32'h0);
    chk("rst_ready", {31'b0, ready}, 32'h1);
    @(negedge clk) rst = 0;

    // x0 writes and issues
    ad = '0; we = 1; wad = 0; wd = 32'hFFFF_FFFF; iv = 1; ird = 0;
    #1 chk("x0_ready", {31'b0, ready}, 32'h1);
    cycle();
    idle(); cycle();
    chk("x0_rd", rd_o[31:0], 32'h0);

    // scoreboard saturation on x7
    ad[0] = 7;
    for (int i = 0; i < 3; i++) begin iv = 1; ird = 7; cycle(); end
    idle(); #1 chk("x7_busy", {31'b0, busy[0]}, 32'h1);
    iv = 1; ird = 7; #1 chk("x7_full", {31'b0, ready}, 32'h0);
    cycle();
    we = 1; wad = 7; wd = 32'hA5; #1 chk("x7_full_wb", {31'b0, ready}, 32'h1);
    cycle();
    iv = 0;
    for (int i = 0; i < 3; i++) cycle();
    idle(); #1 chk("x7_retired", {31'b0, busy[0]}, 32'h0);
    chk("x7_data", rd_o[31:0], 32'hA5);

    // flush with same-edge writeback
    ad[0] = 3;
    for (int i = 0; i < 2; i++) begin iv = 1; ird = 3; cycle(); end
    idle(); fl = 1; we = 1; wad = 3; wd = 32'h77; cycle();
    idle(); #1 chk("flush_busy", {31'b0, busy[0]}, 32'h0);
    chk("flush_rd", rd_o[31:0], 32'h77);
    cycle();

    // write-through behaviour on x9 with one pending write
    ad[0] = 9; we = 1; wad = 9; wd = 32'h1; cycle();
    idle(); iv = 1; ird = 9; cycle();
    idle(); we = 1; wad = 9; wd = 32'hDEAD;
    #1 chk("byp_rd", rd_o[31:0], BYP ? 32'hDEAD : 32'h1);
    chk("byp_busy", {31'b0, busy[0]}, BYP ? 32'h0 : 32'h1);
    cycle();
    idle(); #1 chk("byp_next", rd_o[31:0], 32'hDEAD);
    cycle();

    // multi-port reads
    we = 1; wad = 1; wd = 32'h11; cycle();
    we = 1; wad = 10; wd = 32'h22; cycle();
    idle(); ad[0] = 1; ad[1] = 1; ad[2] = 10;
    #1 chk("mp_rd0", rd_o[31:0], 32'h11);
    chk("mp_rd1", rd_o[63:32], 32'h11);
    chk("mp_rd2", rd_o[95:64], 32'h22);
    chk("mp_a0", a0, 32'h22);
    cycle();

    // randomized traffic on a small register window to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < NR; k++) ad[k] = 5'($urandom_range(0, 11));
      iv  = 1'($urandom_range(0, 1));
      ird = 5'($urandom_range(0, 11));
      we  = ($urandom_range(0, 2) != 0);
      wad = 5'($urandom_range(0, 11));
      wd  = $urandom;
      fl  = ($urandom_range(0, 31) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
